mux_rr_arbiter: RTL
===================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4:1 multiplexed data path among four requesters (A, B, C, D).
- Drives the 2-bit select, registers the selected data onto OUT, and holds each grant for a programmable number of cycles.
- Sits in front of the existing combinational 4:1 mux, or absorbs it, wherever a shared WIDTH-bit bus needs fair time-slicing.

Parameters:
- WIDTH, 4, data width of A/B/C/D/OUT.
- HOLD, 2, maximum consecutive cycles per grant; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; bit0=A, bit1=B, bit2=C, bit3=D.
- A  input  WIDTH  requester 0 data.
- B  input  WIDTH  requester 1 data.
- C  input  WIDTH  requester 2 data.
- D  input  WIDTH  requester 3 data.
- Sel  output  2  registered select index of the current grant.
- OUT  output  WIDTH  registered data of the granted requester.
- out_valid  output  1  high while OUT carries granted data.
- gnt  output  4  registered one-hot grant; all zero when idle.
- busy  output  1  high in GRANT state; equal to out_valid.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: Sel=0, OUT=0, out_valid=0, gnt=0, busy=0, state=IDLE, RR pointer ptr=0, hold counter=0.
- rst has priority over every other event, including mid-grant. The grant is abandoned and all outputs return to reset values at that edge.
- Two states: IDLE and GRANT.
- Arbitration function: search req starting at index ptr, wrapping 3->0. The first set bit wins.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, at the edge: Sel<=winner, gnt<=onehot(winner), OUT<=data[winner], out_valid<=1, cnt<=HOLD-1, go to GRANT.
  - Latency: req high before edge k -> grant and OUT visible after edge k.
- GRANT, each edge:
  - Release condition: cnt==0 OR req[Sel]==0.
  - No release: OUT<=data[Sel], which tracks live input data every cycle; cnt<=cnt-1; Sel and gnt unchanged.
  - Release: ptr<=Sel+1 (mod 4).
    - Then arbitrate among the current req from Sel+1. The current holder is eligible only if no other bit is set.
    - Winner found: load a new grant in the same edge (no idle bubble) and set cnt<=HOLD-1.
    - req==0: go to IDLE, gnt<=0, out_valid<=0, OUT<=0. Sel keeps its last value.
- Grant length: exactly HOLD cycles if req stays high; fewer if the holder drops req. A drop sampled at edge k ends the grant at edge k.
- HOLD=1: every grant lasts one cycle and rotation advances every cycle.
- Changes on non-granted req bits during a grant do not disturb the grant.
- A sole persistent requester is re-granted back-to-back indefinitely, with out_valid continuously high.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt!=0 if and only if out_valid=1.
  - Sel always equals the index of gnt whenever gnt!=0.

Optional Feature:
- Macro MUX_ARB_FIXED_PRIO_EN.
- Defined: the arbitration search always starts at index 0 (fixed priority A>B>C>D). ptr is not updated; HOLD and release rules are unchanged.
- Undefined: round-robin as described above.

Test Plan:
- Reset: A=5, B=6, C=7, D=8, req=1111, rst=1 for 2 edges -> Sel=0, OUT=0, gnt=0000, out_valid=0, busy=0 after each edge.
- Single requester: HOLD=2, req=0100 held -> after the first edge gnt=0100, Sel=2, OUT=7, out_valid=1. It stays granted continuously across hold expiries with no bubble. Change C to 9 mid-grant -> OUT=9 next edge.
- Full load: HOLD=2, req=1111 -> Sel sequence 0,0,1,1,2,2,3,3,0,0; OUT 5,5,6,6,7,7,8,8,5,5; gnt one-hot each cycle.
- Early release: HOLD=4, req=1010, B granted; drop req[1] after 1 cycle -> next edge gnt=1000, Sel=3, OUT=8. When req later goes to 0000 -> IDLE, out_valid=0, OUT=0.
- Reset mid-operation: req=1111, rst pulsed while C is granted -> outputs return to reset values at that edge. After rst deasserts, the first grant is A (ptr reset to 0).
- Macro: HOLD=1, req=1010 -> without MUX_ARB_FIXED_PRIO_EN, Sel alternates 1,3,1,3. With it, Sel=1 every cycle and OUT=6 constantly.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a registered 4:1 data mux with a bounded hold per grant.
// Define MUX_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority A>B>C>D.
module mux_rr_arbiter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned HOLD  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    output logic [1:0]       Sel,
    output logic [WIDTH-1:0] OUT,
    output logic             out_valid,
    output logic [3:0]       gnt,
    output logic             busy
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [3:0] HoldM1 = 4'(HOLD - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [WIDTH-1:0] data [4];
    logic [1:0]       idle_start, rel_start;
    logic [2:0]       pick_idle, pick_rel;

    // Returns {found, index} of the first set bit at or after start, wrapping 3->0.
    function automatic logic [2:0] find_first(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        find_first = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) find_first = {1'b1, idx};
        end
    endfunction

    assign data[0] = A;
    assign data[1] = B;
    assign data[2] = C;
    assign data[3] = D;

`ifdef MUX_ARB_FIXED_PRIO_EN
    assign idle_start = 2'd0;
    assign rel_start  = 2'd0;
`else
    logic [1:0] ptr_q, ptr_d;
    assign idle_start = ptr_q;
    // Starting after the holder makes it eligible only when nobody else is asking.
    assign rel_start  = sel_q + 2'd1;
`endif

    assign pick_idle = find_first(req, idle_start);
    assign pick_rel  = find_first(req, rel_start);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        out_d   = out_q;
        gnt_d   = gnt_q;
`ifndef MUX_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            StIdle: begin
                if (pick_idle[2]) begin
                    state_d = StGrant;
                    sel_d   = pick_idle[1:0];
                    gnt_d   = 4'b0001 << pick_idle[1:0];
                    out_d   = data[pick_idle[1:0]];
                    cnt_d   = HoldM1;
                end
            end
            StGrant: begin
                if (cnt_q == 4'd0 || !req[sel_q]) begin
`ifndef MUX_ARB_FIXED_PRIO_EN
                    ptr_d = sel_q + 2'd1;
`endif
                    if (pick_rel[2]) begin
                        sel_d = pick_rel[1:0];
                        gnt_d = 4'b0001 << pick_rel[1:0];
                        out_d = data[pick_rel[1:0]];
                        cnt_d = HoldM1;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = '0;
                        out_d   = '0;
                    end
                end else begin
                    out_d = data[sel_q];
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sel_q   <= '0;
            out_q   <= '0;
            gnt_q   <= '0;
`ifndef MUX_ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
            gnt_q   <= gnt_d;
`ifndef MUX_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign Sel       = sel_q;
    assign OUT       = out_q;
    assign gnt       = gnt_q;
    assign out_valid = (state_q == StGrant);
    assign busy      = out_valid;

endmodule
